regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port integer register file for the CPU datapath.
//   Supports NREAD combinational read ports, two clocked write ports (W0 = ALU result, W1 = load return),
//   optional write-to-read bypass, read-port swap, and a per-register busy scoreboard for outstanding loads.
//   Sits between decode (read addresses) and writeback (write ports).
// PARAMETERS
//   DATA_W  32  register width in bits
//   ADDR_W  5   address width; depth = 2**ADDR_W registers
//   NREAD   2   number of read ports (>= 2)
//   BYPASS  1   1: same-cycle write data forwarded to matching reads; 0: reads show stored value only
// PORTS
//   clk        in   1               rising-edge clock
//   rst_n      in   1               asynchronous active-low reset
//   we0        in   1               W0 write enable
//   waddr0     in   ADDR_W          W0 address
//   wdata0     in   DATA_W          W0 data
//   we1        in   1               W1 write enable (also clears busy)
//   waddr1     in   ADDR_W          W1 address
//   wdata1     in   DATA_W          W1 data
//   mark       in   1               set busy bit of mark_addr (load issued)
//   mark_addr  in   ADDR_W          register to mark busy
//   swap       in   1               exchange addresses of read ports 0 and 1
//   raddr      in   NREAD*ADDR_W    read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rdata      out  NREAD*DATA_W    read data, port k at [k*DATA_W +: DATA_W]
//   rbusy      out  NREAD           busy bit of register addressed by port k
// BEHAVIOUR
//   - Reset (rst_n=0, async, no clock needed): all registers := 0, all busy bits := 0;
//     while rst_n=0, rdata=0 and rbusy=0 regardless of inputs; writes and marks ignored.
//   - Writes: registered on rising clk. Register 0 is hardwired zero: writes to it are dropped,
//     its busy bit never sets, it always reads 0 with rbusy=0.
//   - Write collision (we0 & we1, waddr0==waddr1): W1 data is stored, W0 dropped.
//   - Reads: combinational, zero cycle latency. Effective address: port0 uses raddr[1] and port1 uses
//     raddr[0] when swap=1; ports >=2 are never swapped.
//   - Bypass (BYPASS=1): if a read's effective address is nonzero and matches an enabled write this cycle,
//     rdata = that write's data (W1 over W0); else stored value. BYPASS=0: stored value only, new value
//     visible from the cycle after the edge.
//   - Scoreboard: busy[mark_addr] := 1 on edge when mark=1 and mark_addr!=0.
//     busy[waddr1] := 0 on edge when we1=1. W0 writes do not touch busy.
//   - Mark and W1 clear on same address in same cycle: busy ends 1 (new load supersedes old).
//   - rbusy[k] reflects stored busy state of the effective address (no bypass of mark/clear).
//   - Reset asserted mid-operation overrides any in-flight write/mark in that cycle.
//   - All addresses fully decoded; no out-of-range condition exists.
// TESTING
//   1. Reset: hold rst_n=0 with we0=1,waddr0=3,wdata0=0xDEAD, clock 3x -> rdata all 0; release, read r3 -> 0.
//   2. Write/read: we0 r5=0x1234 then read r5 next cycle -> 0x1234; write r0=0xFFFF -> r0 reads 0.
//   3. Collision+bypass: we0 r7=0xAAAA & we1 r7=0x5555 same cycle, raddr0=7 -> same-cycle rdata0=0x5555
//      (BYPASS=1); after edge r7=0x5555. With BYPASS=0, same-cycle rdata0 = old r7.
//   4. Swap: r1=0x11, r2=0x22, raddr0=1, raddr1=2, swap=1 -> rdata0=0x22, rdata1=0x11; swap=0 -> reversed.
//   5. Scoreboard: mark r9 -> next cycle rbusy for r9 =1; we1 r9=0x99 -> busy clears after edge, rdata=0x99;
//      mark r9 and we1 r9 same cycle -> busy stays 1; mark r0 -> rbusy stays 0.
//   6. Async reset mid-run: busy r9=1, r5=0x1234, drop rst_n between edges -> rdata/rbusy 0 immediately,
//      and after release r5=0, busy r9=0.

Source files
------------

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ==========================================================================
// Module  : regfile_mp_if
// Purpose : Writeback/decode bus of the multi-port register file.
// Rev     : 1.0  initial release
// ==========================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic                     mark;
  logic [ADDR_W-1:0]        mark_addr;
  logic                     swap;
  logic [NREAD*ADDR_W-1:0]  raddr;
  logic [NREAD*DATA_W-1:0]  rdata;
  logic [NREAD-1:0]         rbusy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1,
    output mark, mark_addr, swap, raddr,
    input  rdata, rbusy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1,
    input  mark, mark_addr, swap, raddr,
    output rdata, rbusy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ==========================================================================
// Module  : regfile_mp
// Purpose : Multi-port register file, two write ports, bypass, busy scoreboard.
// Rev     : 1.0  initial release
// ==========================================================================
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  regfile_mp_if.slave bus
);

  localparam int c_depth = 1 << ADDR_W;

  logic [DATA_W-1:0]       r_mem [c_depth];
  logic [c_depth-1:0]      r_busy;
  logic [ADDR_W-1:0]       w_ea  [NREAD];
  logic [NREAD*DATA_W-1:0] w_rdata;
  logic [NREAD-1:0]        w_rbusy;
  logic                    w_w0_ok;
  logic                    w_w1_ok;
  logic                    w_mark_ok;

  assign w_w0_ok   = bus.we0  && (bus.waddr0 != '0);
  assign w_w1_ok   = bus.we1  && (bus.waddr1 != '0);
  assign w_mark_ok = bus.mark && (bus.mark_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_depth; i++) begin
        r_mem[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      // W1 (load return) wins a same-address collision.
      if (w_w0_ok && !(w_w1_ok && (bus.waddr1 == bus.waddr0))) begin
        r_mem[bus.waddr0] <= bus.wdata0;
      end
      if (w_w1_ok) begin
        r_mem[bus.waddr1] <= bus.wdata1;
      end
      if (bus.we1) begin
        r_busy[bus.waddr1] <= 1'b0;
      end
      // Placed after the clear so a newly issued load keeps the register busy.
      if (w_mark_ok) begin
        r_busy[bus.mark_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    w_rbusy = '0;
    for (int k = 0; k < NREAD; k++) begin
      w_ea[k] = bus.raddr[k*ADDR_W +: ADDR_W];
    end
    if (bus.swap) begin
      w_ea[0] = bus.raddr[ADDR_W +: ADDR_W];
      w_ea[1] = bus.raddr[0 +: ADDR_W];
    end
    for (int k = 0; k < NREAD; k++) begin
      w_rdata[k*DATA_W +: DATA_W] = r_mem[w_ea[k]];
      if ((BYPASS != 0) && (w_ea[k] != '0)) begin
        if (bus.we1 && (bus.waddr1 == w_ea[k])) begin
          w_rdata[k*DATA_W +: DATA_W] = bus.wdata1;
        end else if (bus.we0 && (bus.waddr0 == w_ea[k])) begin
          w_rdata[k*DATA_W +: DATA_W] = bus.wdata0;
        end
      end
      w_rbusy[k] = r_busy[w_ea[k]];
    end
    // Bypassed write data must not leak out while reset is held.
    if (!rst_n) begin
      w_rdata = '0;
      w_rbusy = '0;
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.rbusy = w_rbusy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ==========================================================================
// Module  : tb_regfile_mp
// Purpose : Directed scoreboard bench, bypass and non-bypass builds side by side.
// Rev     : 1.0  initial release
// ==========================================================================
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus_b ();
  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR)) bus_n ();

  assign bus_n.we0       = bus_b.we0;
  assign bus_n.waddr0    = bus_b.waddr0;
  assign bus_n.wdata0    = bus_b.wdata0;
  assign bus_n.we1       = bus_b.we1;
  assign bus_n.waddr1    = bus_b.waddr1;
  assign bus_n.wdata1    = bus_b.wdata1;
  assign bus_n.mark      = bus_b.mark;
  assign bus_n.mark_addr = bus_b.mark_addr;
  assign bus_n.swap      = bus_b.swap;
  assign bus_n.raddr     = bus_b.raddr;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .BYPASS(0)) u_dut_n (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [31:0] rd_b(input int k);
    return bus_b.rdata[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rd_n(input int k);
    return bus_n.rdata[k*DW +: DW];
  endfunction

  // Read port k on both builds: exp_b for bypass build, exp_n for stored-only build.
  task automatic rd_chk(input string tag, input int k,
                        input logic [31:0] exp_b, input logic [31:0] exp_n);
    push({tag, "_byp"}, exp_b);
    chk(rd_b(k));
    push({tag, "_nobyp"}, exp_n);
    chk(rd_n(k));
  endtask

  task automatic busy_chk(input string tag, input int k, input logic exp);
    push({tag, "_byp"}, {31'b0, exp});
    chk({31'b0, bus_b.rbusy[k]});
    push({tag, "_nobyp"}, {31'b0, exp});
    chk({31'b0, bus_n.rbusy[k]});
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2);
    bus_b.raddr = {a2, a1, a0};
  endtask

  task automatic idle();
    bus_b.we0  = 1'b0;
    bus_b.we1  = 1'b0;
    bus_b.mark = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_b.we0       = 1'b1;
    bus_b.waddr0    = 5'd3;
    bus_b.wdata0    = 32'hDEAD;
    bus_b.we1       = 1'b0;
    bus_b.waddr1    = 5'd0;
    bus_b.wdata1    = 32'h0;
    bus_b.mark      = 1'b1;
    bus_b.mark_addr = 5'd4;
    bus_b.swap      = 1'b0;
    set_rd(5'd3, 5'd4, 5'd3);

    // Reset held across edges with a write and mark pending
    repeat (3) tick();
    rd_chk("rst_rd0", 0, 32'h0, 32'h0);
    rd_chk("rst_rd2", 2, 32'h0, 32'h0);
    busy_chk("rst_busy1", 1, 1'b0);
    rst_n = 1'b1;
    idle();
    #1;
    rd_chk("rel_r3", 0, 32'h0, 32'h0);
    busy_chk("rel_busy_r4", 1, 1'b0);

    // Basic write/read and hardwired r0
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd5; bus_b.wdata0 = 32'h1234;
    tick();
    idle();
    set_rd(5'd5, 5'd0, 5'd5);
    #1;
    rd_chk("wr_r5", 0, 32'h1234, 32'h1234);
    rd_chk("wr_r5_p2", 2, 32'h1234, 32'h1234);
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd0; bus_b.wdata0 = 32'hFFFF;
    #1;
    rd_chk("r0_samecyc", 1, 32'h0, 32'h0);
    tick();
    idle();
    #1;
    rd_chk("r0_after", 1, 32'h0, 32'h0);

    // Collision on r7 plus W0-only bypass on r6
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd7; bus_b.wdata0 = 32'hAAAA;
    bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd7; bus_b.wdata1 = 32'h5555;
    set_rd(5'd7, 5'd7, 5'd6);
    #1;
    rd_chk("coll_samecyc", 0, 32'h5555, 32'h0);
    tick();
    idle();
    #1;
    rd_chk("coll_after", 1, 32'h5555, 32'h5555);
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd6; bus_b.wdata0 = 32'h66;
    #1;
    rd_chk("w0_bypass", 2, 32'h66, 32'h0);
    tick();
    idle();
    #1;
    rd_chk("w0_after", 2, 32'h66, 32'h66);

    // Swap of ports 0/1; port 2 unaffected
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd1; bus_b.wdata0 = 32'h11;
    bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd2; bus_b.wdata1 = 32'h22;
    tick();
    idle();
    set_rd(5'd1, 5'd2, 5'd1);
    bus_b.swap = 1'b1;
    #1;
    rd_chk("swap_p0", 0, 32'h22, 32'h22);
    rd_chk("swap_p1", 1, 32'h11, 32'h11);
    rd_chk("swap_p2", 2, 32'h11, 32'h11);
    bus_b.swap = 1'b0;
    #1;
    rd_chk("noswap_p0", 0, 32'h11, 32'h11);
    rd_chk("noswap_p1", 1, 32'h22, 32'h22);

    // Scoreboard
    bus_b.mark = 1'b1; bus_b.mark_addr = 5'd9;
    set_rd(5'd9, 5'd0, 5'd8);
    #1;
    busy_chk("mark_samecyc", 0, 1'b0);
    tick();
    idle();
    #1;
    busy_chk("mark_r9", 0, 1'b1);
    busy_chk("mark_r8_clean", 2, 1'b0);
    bus_b.we1 = 1'b1; bus_b.waddr1 = 5'd9; bus_b.wdata1 = 32'h99;
    #1;
    busy_chk("clr_samecyc", 0, 1'b1);
    rd_chk("ld_bypass", 0, 32'h99, 32'h0);
    tick();
    idle();
    #1;
    busy_chk("clr_after", 0, 1'b0);
    rd_chk("ld_after", 0, 32'h99, 32'h99);
    bus_b.mark = 1'b1; bus_b.mark_addr = 5'd9;
    bus_b.we1  = 1'b1; bus_b.waddr1 = 5'd9; bus_b.wdata1 = 32'h9A;
    tick();
    idle();
    #1;
    busy_chk("mark_clr_same", 0, 1'b1);
    rd_chk("mark_clr_data", 0, 32'h9A, 32'h9A);
    bus_b.mark = 1'b1; bus_b.mark_addr = 5'd0;
    tick();
    idle();
    #1;
    busy_chk("mark_r0", 1, 1'b0);
    bus_b.we0 = 1'b1; bus_b.waddr0 = 5'd9; bus_b.wdata0 = 32'h77;
    tick();
    idle();
    #1;
    busy_chk("w0_keeps_busy", 0, 1'b1);
    rd_chk("w0_r9", 0, 32'h77, 32'h77);

    // Async reset between edges with a write and mark in flight
    set_rd(5'd5, 5'd9, 5'd10);
    bus_b.we0  = 1'b1; bus_b.waddr0 = 5'd5; bus_b.wdata0 = 32'hBEEF;
    bus_b.mark = 1'b1; bus_b.mark_addr = 5'd10;
    #1;
    rd_chk("pre_arst_r5", 0, 32'hBEEF, 32'h1234);
    #1;
    rst_n = 1'b0;
    #1;
    rd_chk("arst_r5", 0, 32'h0, 32'h0);
    busy_chk("arst_busy_r9", 1, 1'b0);
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    rd_chk("post_arst_r5", 0, 32'h0, 32'h0);
    busy_chk("post_arst_r9", 1, 1'b0);
    busy_chk("post_arst_r10", 2, 1'b0);
    rd_chk("post_arst_r9", 1, 32'h0, 32'h0);

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
